// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: requests the bus by holding the clock low,
// then shifts a command byte, odd parity and stop bit out on device clock
// falls, checks the device acknowledge and guards the frame with a watchdog.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 1500,
  parameter int TIMEOUT_CYCLES = 215000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    BITS,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cntInc;
  logic [7:0]    data_q, data_d;
  logic          parity_q, parity_d;
  logic [3:0]    bitCnt_q, bitCnt_d;
  logic          clkOe_q, clkOe_d;
  logic          dataOe_q, dataOe_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [1:0]    clkSync_q, dataSync_q;
  logic          clkPrev_q;
  logic          fall;
  logic          timeout;

  // Bring the asynchronous bus pins into the clk domain and keep clock history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clkSync_q  <= 2'b11;
      dataSync_q <= 2'b11;
      clkPrev_q  <= 1'b1;
    end else begin
      clkSync_q  <= {clkSync_q[0], ps2_clk_in};
      dataSync_q <= {dataSync_q[0], ps2_data_in};
      clkPrev_q  <= clkSync_q[1];
    end
  end

  assign fall    = clkPrev_q & ~clkSync_q[1];
  assign cntInc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign timeout = (cnt_q == TO_LAST);

  // State, counter, latched byte and registered pin drives / status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      parity_q <= 1'b0;
      bitCnt_q <= '0;
      clkOe_q  <= 1'b0;
      dataOe_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      parity_q <= parity_d;
      bitCnt_q <= bitCnt_d;
      clkOe_q  <= clkOe_d;
      dataOe_q <= dataOe_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  // Frame sequencing: the counter times the inhibit/start phases and doubles as the fall watchdog
  always_comb begin
    state_d  = state_q;
    cnt_d    = cntInc;
    data_d   = data_q;
    parity_d = parity_q;
    bitCnt_d = bitCnt_q;
    clkOe_d  = clkOe_q;
    dataOe_d = dataOe_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    case (state_q)
      IDLE: begin
        clkOe_d  = 1'b0;
        dataOe_d = 1'b0;
        cnt_d    = '0;
        if (tx_valid) begin
          data_d   = tx_data;
          parity_d = ~^tx_data;
          clkOe_d  = 1'b1;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d    = '0;
          dataOe_d = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        if (timeout) begin
          clkOe_d  = 1'b0;
          dataOe_d = 1'b0;
          error_d  = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == CW'(1)) begin
          cnt_d    = '0;
          clkOe_d  = 1'b0;
          bitCnt_d = '0;
          state_d  = BITS;
        end
      end
      BITS: begin
        if (fall) begin
          cnt_d    = '0;
          bitCnt_d = bitCnt_q + 4'd1;
          if (bitCnt_q < 4'd8) begin
            dataOe_d = ~data_q[bitCnt_q[2:0]];
          end else if (bitCnt_q == 4'd8) begin
            dataOe_d = ~parity_q;
          end else begin
            dataOe_d = 1'b0;
            state_d  = ACK;
          end
        end else if (timeout) begin
          clkOe_d  = 1'b0;
          dataOe_d = 1'b0;
          error_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      ACK: begin
        if (fall) begin
          cnt_d = '0;
          if (!dataSync_q[1]) begin
            state_d = WAIT_IDLE;
          end else begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end else if (timeout) begin
          clkOe_d  = 1'b0;
          dataOe_d = 1'b0;
          error_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      WAIT_IDLE: begin
        if (fall) begin
          cnt_d = '0;
        end
        if (clkSync_q[1] && dataSync_q[1]) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (timeout && !fall) begin
          clkOe_d  = 1'b0;
          dataOe_d = 1'b0;
          error_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        clkOe_d  = 1'b0;
        dataOe_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  assign tx_ready    = (state_q == IDLE);
  assign rx_inhibit  = (state_q != IDLE);
  assign ps2_clk_oe  = clkOe_q;
  assign ps2_data_oe = dataOe_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural PS/2 device clocks frames
// out of the host; sampled bits and outcomes are compared to a frame model.
module tb_ps2_host_tx;

  localparam int INH = 60;
  localparam int TO  = 400;
  localparam int FULL = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       tx_done, tx_error, rx_inhibit;
  logic       devClk = 1'b1;
  logic       devData = 1'b1;
  logic       ps2ClkIn, ps2DataIn;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int donePulses = 0;
  int errorPulses = 0;
  int overlap = 0;
  int badReady = 0;
  int badInhibit = 0;
  int doneQ[$];
  int acceptCycle;

  // Open-drain bus: either side pulling low wins
  assign ps2ClkIn  = ~ps2_clk_oe & devClk;
  assign ps2DataIn = ~ps2_data_oe & devData;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2ClkIn),
    .ps2_data_in(ps2DataIn),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .rx_inhibit (rx_inhibit)
  );

  // Continuous protocol observations, sampled away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_done) begin
        donePulses++;
        doneQ.push_back(cycle);
      end
      if (tx_error) errorPulses++;
      if (tx_done && tx_error) overlap++;
      if ((ps2_clk_oe || ps2_data_oe) && tx_ready) badReady++;
      if (rx_inhibit == tx_ready) badInhibit++;
    end
  end

  // Hard stop in case something hangs outside the bounded waits
  initial begin
    #5000000;
    $display("[TB] FAIL globalTimeout: simulation exceeded time limit");
    $fatal(1, "[TB] aborted");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Line levels the device should see after falls 1..10: data LSB first, odd parity, stop
  function automatic logic [10:1] expFrame(input logic [7:0] b);
    logic [10:1] r;
    for (int k = 1; k <= 8; k++) r[k] = ((b >> (k - 1)) & 8'd1) != 8'd0;
    r[9]  = ($countones(b) % 2) == 0;
    r[10] = 1'b1;
    return r;
  endfunction

  task automatic applyStimulus(input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    while (!tx_ready && guard < 5000) begin
      guard++;
      @(negedge clk);
    end
    if (!tx_ready) begin
      checkOutput("readyWait", 32'(tx_ready), 32'd1);
      return;
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    acceptCycle = cycle;
    tx_valid = 1'b0;
  endtask

  // Behavioural device: waits for the request-to-send, then clocks the frame
  task automatic deviceRespond(input int half, input int stopAfter, input bit ackLow,
                               output logic [10:1] seen, output int inh, output int st,
                               output int fallCycle, output bit ok);
    int guard = 0;
    seen = '0;
    inh = 0;
    st = 0;
    fallCycle = 0;
    ok = 1'b1;
    @(negedge clk);
    while (!ps2_clk_oe && guard < 6000) begin
      guard++;
      @(negedge clk);
    end
    if (!ps2_clk_oe) begin
      ok = 1'b0;
      return;
    end
    while (ps2_clk_oe && !ps2_data_oe && inh < INH + 20) begin
      inh++;
      @(negedge clk);
    end
    while (ps2_clk_oe && ps2_data_oe && st < 20) begin
      st++;
      @(negedge clk);
    end
    if (ps2_clk_oe || !ps2_data_oe) begin
      ok = 1'b0;
      return;
    end
    repeat (half) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ackLow) devData = 1'b0;
      devClk = 1'b0;
      fallCycle = cycle;
      if (k == stopAfter) return;
      repeat (half) @(negedge clk);
      if (k <= 10) seen[k] = ps2DataIn;
      devClk = 1'b1;
      repeat (half) @(negedge clk);
    end
    devData = 1'b1;
  endtask

  task automatic runFrame(input logic [7:0] b, input int half, input bit ackLow, input string tag);
    logic [10:1] seen;
    int inh, st, fc, d0, e0;
    bit ok;
    d0 = donePulses;
    e0 = errorPulses;
    fork
      applyStimulus(b);
      deviceRespond(half, FULL, ackLow, seen, inh, st, fc, ok);
    join
    repeat (10) @(negedge clk);
    checkOutput({tag, ".sync"}, 32'(ok), 32'd1);
    checkOutput({tag, ".bits"}, 32'(seen), 32'(expFrame(b)));
    checkOutput({tag, ".inhibit"}, 32'(inh), 32'(INH));
    checkOutput({tag, ".start"}, 32'(st), 32'd2);
    checkOutput({tag, ".done"}, 32'(donePulses - d0), ackLow ? 32'd1 : 32'd0);
    checkOutput({tag, ".error"}, 32'(errorPulses - e0), ackLow ? 32'd0 : 32'd1);
    checkOutput({tag, ".idle"}, 32'(tx_ready), 32'd1);
  endtask

  initial begin
    logic [10:1] seen, s1, s2, ef;
    int inh, st, fc, d0, e0, g, acc1, acc2, half;
    bit ok, ok2, ack;
    logic [7:0] b;

    rst_n = 1'b0;
    tx_data = '0;
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst.ready", 32'(tx_ready), 32'd1);
    checkOutput("rst.clkOe", 32'(ps2_clk_oe), 32'd0);
    checkOutput("rst.dataOe", 32'(ps2_data_oe), 32'd0);
    checkOutput("rst.pulses", 32'({tx_done, tx_error}), 32'd0);
    checkOutput("rst.inhibit", 32'(rx_inhibit), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] frame 0xED with ack");
    runFrame(8'hED, 20, 1'b1, "ed");
    $display("[TB] frame 0xF4 with ack");
    runFrame(8'hF4, 25, 1'b1, "f4");

    $display("[TB] NACK frame");
    runFrame(8'($urandom), 15, 1'b0, "nack");

    $display("[TB] device stops after fall 4");
    d0 = donePulses;
    e0 = errorPulses;
    fork
      applyStimulus(8'($urandom));
      deviceRespond(18, 4, 1'b1, seen, inh, st, fc, ok);
    join
    g = 0;
    while (!tx_error && g < TO + 50) begin
      @(negedge clk);
      g++;
    end
    checkOutput("to.sync", 32'(ok), 32'd1);
    checkOutput("to.latency", 32'(cycle - fc), 32'(TO + 3));
    checkOutput("to.oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    devClk = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("to.errorCount", 32'(errorPulses - e0), 32'd1);
    checkOutput("to.noDone", 32'(donePulses - d0), 32'd0);
    checkOutput("to.idle", 32'(tx_ready), 32'd1);

    $display("[TB] reset during BITS at fall 5");
    b = 8'($urandom) & 8'hEF;
    fork
      applyStimulus(b);
      deviceRespond(20, 5, 1'b1, seen, inh, st, fc, ok);
    join
    repeat (6) @(negedge clk);
    ef = expFrame(b);
    checkOutput("rstmid.sync", 32'(ok), 32'd1);
    checkOutput("rstmid.bit5", 32'(ps2DataIn), 32'(ef[5]));
    checkOutput("rstmid.preOe", 32'(ps2_data_oe), 32'd1);
    d0 = donePulses;
    e0 = errorPulses;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid.oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    checkOutput("rstmid.ready", 32'(tx_ready), 32'd1);
    devClk = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("rstmid.pulses", 32'((donePulses - d0) + (errorPulses - e0)), 32'd0);
    checkOutput("rstmid.readyAfter", 32'(tx_ready), 32'd1);
    runFrame(8'h00, 20, 1'b1, "zero");

    $display("[TB] back-to-back 0x01 then 0xFF with valid held");
    d0 = donePulses;
    acc1 = 0;
    acc2 = 0;
    fork
      begin
        @(negedge clk);
        tx_data = 8'h01;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        acc1 = cycle;
        tx_data = 8'hFF;
        g = 0;
        @(negedge clk);
        while (!tx_ready && g < 6000) begin
          g++;
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        acc2 = cycle;
        tx_valid = 1'b0;
      end
      begin
        deviceRespond(16, FULL, 1'b1, s1, inh, st, fc, ok);
        deviceRespond(16, FULL, 1'b1, s2, inh, st, fc, ok2);
      end
    join
    repeat (10) @(negedge clk);
    checkOutput("b2b.sync", 32'({ok, ok2}), 32'd3);
    checkOutput("b2b.bits1", 32'(s1), 32'(expFrame(8'h01)));
    checkOutput("b2b.bits2", 32'(s2), 32'(expFrame(8'hFF)));
    checkOutput("b2b.parity1", 32'(s1[9]), 32'd0);
    checkOutput("b2b.parity2", 32'(s2[9]), 32'd1);
    checkOutput("b2b.doneCount", 32'(donePulses - d0), 32'd2);
    if (doneQ.size() > d0) begin
      checkOutput("b2b.secondAccept", 32'(acc2), 32'(doneQ[d0] + 1));
    end else begin
      checkOutput("b2b.firstDone", 32'(doneQ.size()), 32'(d0 + 1));
    end
    checkOutput("b2b.firstAccept", 32'(acc1 != 0), 32'd1);

    $display("[TB] randomized frames");
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      half = int'($urandom_range(12, 30));
      ack = ($urandom_range(0, 3) != 0);
      runFrame(b, half, ack, $sformatf("rand%0d", i));
    end

    checkOutput("doneErrOverlap", 32'(overlap), 32'd0);
    checkOutput("readyDuringFrame", 32'(badReady), 32'd0);
    checkOutput("inhibitVsReady", 32'(badInhibit), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 1500: clock-low hold time before the start bit (about 105 us at 14.318 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 215000: longest allowed gap between device clock falling edges (about 15 ms at 14.318 MHz).
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port tx_data, input, 8: command byte to send to the keyboard or mouse.
REQ-006 SHALL have port tx_valid, input, 1: request; the byte is accepted in a cycle where tx_valid and tx_ready are both 1.
REQ-007 SHALL have port tx_ready, output, 1: high only in IDLE.
REQ-008 SHALL have port ps2_clk_in, input, 1: raw PS/2 clock pin level (asynchronous).
REQ-009 SHALL have port ps2_data_in, input, 1: raw PS/2 data pin level (asynchronous).
REQ-010 SHALL have port ps2_clk_oe, output, 1: 1 drives the clock pin low; 0 releases it (pull-up).
REQ-011 SHALL have port ps2_data_oe, output, 1: 1 drives the data pin low; 0 releases it.
REQ-012 SHALL have port tx_done, output, 1: one-cycle pulse after the device acknowledges the byte.
REQ-013 SHALL have port tx_error, output, 1: one-cycle pulse on NACK or timeout.
REQ-014 SHALL have port rx_inhibit, output, 1: high in every state except IDLE, so the receiver ignores the bus.

Function
REQ-015 SHALL pass ps2_clk_in and ps2_data_in through a 2-flop synchronizer each, then one more history flop on the clock; fall = previous synced clock 1 and current 0.
REQ-016 SHALL use states IDLE, INHIBIT, START, BITS, ACK, WAIT_IDLE.
REQ-017 IDLE: on accept, SHALL latch tx_data, compute odd parity (parity bit = ~^tx_data), load the cycle counter with 0, and go to INHIBIT.
REQ-018 INHIBIT: ps2_clk_oe=1 and ps2_data_oe=0; after INHIBIT_CYCLES cycles SHALL go to START.
REQ-019 START: ps2_clk_oe=1 and ps2_data_oe=1 for exactly 2 cycles, then SHALL go to BITS with ps2_clk_oe=0, ps2_data_oe=1 (start bit) and bit index 0.
REQ-020 BITS: on each fall, SHALL set ps2_data_oe = ~bit, where bit is chosen by fall number: 1..8 → data[0..7] LSB first; 9 → parity; 10 → 0 (stop, data line released). Fall 10 SHALL go to ACK.
REQ-021 ACK: on the next fall, SHALL sample synced data; 0 → WAIT_IDLE (ack), 1 → tx_error pulse and go to IDLE (NACK).
REQ-022 WAIT_IDLE: when synced clock and data are both 1, SHALL pulse tx_done and go to IDLE.
REQ-023 Watchdog: in START, BITS, ACK and WAIT_IDLE, SHALL count cycles, clearing the count on each fall; on reaching TIMEOUT_CYCLES it SHALL release both oe signals, pulse tx_error and go to IDLE.
REQ-024 tx_done and tx_error SHALL never be asserted in the same cycle.
REQ-025 tx_valid outside IDLE SHALL be ignored; there is no queueing.
REQ-026 A fall seen during INHIBIT or START SHALL be ignored, because the host drive overrides the device.
REQ-027 The cycle counter SHALL be wide enough for max(INHIBIT_CYCLES, TIMEOUT_CYCLES) and SHALL saturate rather than wrap.

Reset
REQ-028 While rst_n=0: state IDLE, tx_ready=1, ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_error=0, rx_inhibit=0, synchronizers set to 1.
REQ-029 Reset asserted mid-frame SHALL release both lines immediately (asynchronously) and SHALL NOT pulse tx_done or tx_error.

Verification
REQ-030 tx_data=0xED with a device model clocking at 12 kHz and driving ack → data line after falls 1..10 reads 1,0,1,1,0,1,1,1,1(parity),1(stop); tx_done pulses once.
REQ-031 tx_data=0xF4 → parity bit 0; clock held low for exactly 1500 cycles before the start bit; tx_ready=0 throughout the frame.
REQ-032 Device leaves data high at fall 11 → tx_error pulses one cycle, tx_done stays 0, state returns to IDLE.
REQ-033 Device stops clocking after fall 4 → tx_error exactly 215000 cycles after the last fall; both oe signals are 0.
REQ-034 rst_n pulsed low during BITS at fall 5 → both oe signals go to 0 immediately; after release tx_ready=1, and a new 0x00 frame (parity 1) completes normally.
REQ-035 tx_valid held high for two back-to-back bytes 0x01 then 0xFF → the second byte is accepted only after the first tx_done; parity bits are 0 and 1 respectively.
